// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register access blocks.
// Latency: none (types only).
// Backpressure: not applicable.
//
// rggen_status is the two-bit response code returned with every access.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    // Response code for a decoded access: an address miss outranks a
    // permission failure.
    function automatic rggen_status access_status(input logic match,
                                                  input logic permitted);
        if (!match) begin
            return RGGEN_DECODE_ERROR;
        end else if (!permitted) begin
            return RGGEN_SLAVE_ERROR;
        end else begin
            return RGGEN_OKAY;
        end
    endfunction

endpackage

// File: rtl/rggen_register_access_decoder.sv
// Address/permission decoder for one register.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   address   : byte address of the request
//   write     : 1 = write, 0 = read
//   match     : address equals OFFSET_ADDRESS exactly
//   permitted : the access direction is allowed for this register
module rggen_register_access_decoder #(
    parameter int                     ADDRESS_WIDTH  = 8,
    parameter bit [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter bit                     READABLE       = 1'b1,
    parameter bit                     WRITABLE       = 1'b1
) (
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     write,
    output logic                     match,
    output logic                     permitted
);

    assign match     = (address == OFFSET_ADDRESS);
    assign permitted = write ? WRITABLE : READABLE;

endmodule

// File: rtl/rggen_register_access_initiator.sv
// Initiator end of the bit-field access protocol for a single register.
// Latency: bit-field strobe 1 cycle after accept, response 2 cycles after accept.
// Backpressure: one access in flight; request ready only in IDLE, response held until i_rsp_ready.
//
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_req_* / o_req_ready : bus-side request (address, write, write data, per-bit strobe)
//   o_rsp_* / i_rsp_ready : held response (status, read data)
//   o_bf_*                : single-cycle bit-field access (valid, masks, write data)
//   i_bf_read_data        : read data returned by the bit fields
module rggen_register_access_initiator
    import rggen_rtl_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH  = 8,
    parameter int                     DATA_WIDTH     = 32,
    parameter bit [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter bit                     READABLE       = 1'b1,
    parameter bit                     WRITABLE       = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    input  logic                     i_req_write,
    input  logic [DATA_WIDTH-1:0]    i_req_write_data,
    input  logic [DATA_WIDTH-1:0]    i_req_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [DATA_WIDTH-1:0]    o_rsp_read_data,
    output logic                     o_bf_valid,
    output logic [DATA_WIDTH-1:0]    o_bf_read_mask,
    output logic [DATA_WIDTH-1:0]    o_bf_write_mask,
    output logic [DATA_WIDTH-1:0]    o_bf_write_data,
    input  logic [DATA_WIDTH-1:0]    i_bf_read_data
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESPONSE = 2'd2
    } state_t;

    state_t      state;
    logic        access_write;
    rggen_status access_result;
    logic        match;
    logic        permitted;

    // The request is decoded as it is accepted; only the decode result and
    // direction need to survive into ACCESS, because the bit-field outputs
    // are registered on the accept edge and so already carry the captured
    // write data and strobe.
    rggen_register_access_decoder #(
        .ADDRESS_WIDTH  (ADDRESS_WIDTH),
        .OFFSET_ADDRESS (OFFSET_ADDRESS),
        .READABLE       (READABLE),
        .WRITABLE       (WRITABLE)
    ) u_decoder (
        .address   (i_req_address),
        .write     (i_req_write),
        .match     (match),
        .permitted (permitted)
    );

    assign o_req_ready = (state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            access_write    <= 1'b0;
            access_result   <= RGGEN_OKAY;
            o_rsp_valid     <= 1'b0;
            o_rsp_status    <= 2'b00;
            o_rsp_read_data <= '0;
            o_bf_valid      <= 1'b0;
            o_bf_read_mask  <= '0;
            o_bf_write_mask <= '0;
            o_bf_write_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        state         <= ACCESS;
                        access_write  <= i_req_write;
                        access_result <= access_status(match, permitted);
                        // The strobe is raised here and cleared on the very
                        // next edge, so a clear-on-read field sees exactly
                        // one access.
                        if (match && permitted) begin
                            o_bf_valid      <= 1'b1;
                            o_bf_read_mask  <= i_req_write ? '0 : '1;
                            o_bf_write_mask <= i_req_write ? i_req_strobe : '0;
                            if (i_req_write) begin
                                o_bf_write_data <= i_req_write_data;
                            end
                        end
                    end
                end
                ACCESS: begin
                    state           <= RESPONSE;
                    o_bf_valid      <= 1'b0;
                    o_bf_read_mask  <= '0;
                    o_bf_write_mask <= '0;
                    o_rsp_valid     <= 1'b1;
                    o_rsp_status    <= access_result;
                    // Read data is only meaningful for a successful read.
                    o_rsp_read_data <= ((access_result == RGGEN_OKAY) && !access_write)
                                       ? i_bf_read_data : '0;
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_register_access_initiator.sv
module tb_rggen_register_access_initiator;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam logic [AW-1:0] OFF = 8'h10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic          req_write = 1'b0;
    logic [DW-1:0] req_write_data = '0;
    logic [DW-1:0] req_strobe = '0;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] bf_read_data;

    // Instance a: read/write register. Instance b: read-only (WRITABLE=0).
    logic          a_req_ready, a_rsp_valid, a_bf_valid;
    logic [1:0]    a_rsp_status;
    logic [DW-1:0] a_rsp_read_data, a_bf_read_mask, a_bf_write_mask, a_bf_write_data;
    logic          b_req_ready, b_rsp_valid, b_bf_valid;
    logic [1:0]    b_rsp_status;
    logic [DW-1:0] b_rsp_read_data, b_bf_read_mask, b_bf_write_mask, b_bf_write_data;

    always #5 clk = ~clk;

    rggen_register_access_initiator #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_ADDRESS(OFF),
        .READABLE(1'b1), .WRITABLE(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(a_req_ready),
        .i_req_address(req_address), .i_req_write(req_write),
        .i_req_write_data(req_write_data), .i_req_strobe(req_strobe),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_status(a_rsp_status), .o_rsp_read_data(a_rsp_read_data),
        .o_bf_valid(a_bf_valid), .o_bf_read_mask(a_bf_read_mask),
        .o_bf_write_mask(a_bf_write_mask), .o_bf_write_data(a_bf_write_data),
        .i_bf_read_data(bf_read_data)
    );

    rggen_register_access_initiator #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_ADDRESS(OFF),
        .READABLE(1'b1), .WRITABLE(1'b0)
    ) dut_ro (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(b_req_ready),
        .i_req_address(req_address), .i_req_write(req_write),
        .i_req_write_data(req_write_data), .i_req_strobe(req_strobe),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_status(b_rsp_status), .o_rsp_read_data(b_rsp_read_data),
        .o_bf_valid(b_bf_valid), .o_bf_read_mask(b_bf_read_mask),
        .o_bf_write_mask(b_bf_write_mask), .o_bf_write_data(b_bf_write_data),
        .i_bf_read_data(bf_read_data)
    );

    // Clear-on-read field seen by instance a: returns the seed until the
    // first read strobe after seeding, then 0.
    int            cor_clears = 0;
    int            cor_base = 0;
    logic [DW-1:0] cor_seed = '0;
    assign bf_read_data = (cor_clears == cor_base) ? cor_seed : '0;
    always @(posedge clk) if (a_bf_valid && (a_bf_read_mask != '0)) cor_clears <= cor_clears + 1;

    // ---------------- transaction-level model ----------------
    // At most one transaction in flight; its timing is expressed as cycle
    // offsets from the accepting edge.
    int            cyc = 0;
    logic          pending = 1'b0;
    int            t_acc = 0;
    logic [AW-1:0] t_addr = '0;
    logic          t_write = 1'b0;
    logic [DW-1:0] t_wdata = '0, t_strobe = '0, t_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else begin
            if (pending && cyc == t_acc + 1) t_rdata <= bf_read_data;
            if (pending && cyc >= t_acc + 2 && rsp_ready) begin
                pending <= 1'b0;
            end else if (!pending && req_valid) begin
                pending  <= 1'b1;
                t_acc    <= cyc;
                t_addr   <= req_address;
                t_write  <= req_write;
                t_wdata  <= req_write_data;
                t_strobe <= req_strobe;
            end
        end
    end

    // ---------------- raw observation monitors ----------------
    int            acc_q[$];
    int            hs_q[$];
    logic [33:0]   a_obs[$];
    logic [33:0]   b_obs[$];
    int            a_pulses = 0, b_pulses = 0;
    logic [DW-1:0] last_rmask = '0, last_wmask = '0, last_wdata = '0;

    always @(posedge clk) begin
        if (rst_n && a_req_ready && req_valid) acc_q.push_back(cyc);
        if (rst_n && a_rsp_valid && rsp_ready) begin
            hs_q.push_back(cyc);
            a_obs.push_back({a_rsp_status, a_rsp_read_data});
        end
        if (rst_n && b_rsp_valid && rsp_ready) b_obs.push_back({b_rsp_status, b_rsp_read_data});
    end

    always @(negedge clk) begin
        if (rst_n && a_bf_valid) begin
            a_pulses   <= a_pulses + 1;
            last_rmask <= a_bf_read_mask;
            last_wmask <= a_bf_write_mask;
            last_wdata <= a_bf_write_data;
        end
        if (rst_n && b_bf_valid) b_pulses <= b_pulses + 1;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input bit wen, input logic ready, input logic rv,
                            input logic [1:0] st, input logic [DW-1:0] rd, input logic bv,
                            input logic [DW-1:0] rm, input logic [DW-1:0] wm,
                            input logic [DW-1:0] wd);
        logic ok, exp_bf, exp_rsp;
        logic [1:0] exp_st;
        ok      = pending && (t_addr == OFF) && (t_write ? wen : 1'b1);
        exp_bf  = pending && (cyc == t_acc + 1) && ok;
        exp_rsp = pending && (cyc >= t_acc + 2);
        exp_st  = (t_addr != OFF) ? 2'b11 : (ok ? 2'b00 : 2'b10);
        chk({tag, ".req_ready"}, 64'(ready), 64'(!pending));
        chk({tag, ".bf_valid"}, 64'(bv), 64'(exp_bf));
        if (exp_bf) begin
            chk({tag, ".bf_read_mask"}, 64'(rm), t_write ? 64'd0 : 64'hFFFF_FFFF);
            chk({tag, ".bf_write_mask"}, 64'(wm), t_write ? 64'(t_strobe) : 64'd0);
            if (t_write) chk({tag, ".bf_write_data"}, 64'(wd), 64'(t_wdata));
        end else begin
            chk({tag, ".idle_read_mask"}, 64'(rm), 64'd0);
            chk({tag, ".idle_write_mask"}, 64'(wm), 64'd0);
        end
        chk({tag, ".rsp_valid"}, 64'(rv), 64'(exp_rsp));
        if (exp_rsp) begin
            chk({tag, ".rsp_status"}, 64'(st), 64'(exp_st));
            chk({tag, ".rsp_data"}, 64'(rd), (ok && !t_write) ? 64'(t_rdata) : 64'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            cmp_inst("a", 1'b1, a_req_ready, a_rsp_valid, a_rsp_status, a_rsp_read_data,
                     a_bf_valid, a_bf_read_mask, a_bf_write_mask, a_bf_write_data);
            cmp_inst("b", 1'b0, b_req_ready, b_rsp_valid, b_rsp_status, b_rsp_read_data,
                     b_bf_valid, b_bf_read_mask, b_bf_write_mask, b_bf_write_data);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".a_rsp_valid"}, 64'(a_rsp_valid), 64'd0);
        chk({tag, ".a_rsp_status"}, 64'(a_rsp_status), 64'd0);
        chk({tag, ".a_rsp_data"}, 64'(a_rsp_read_data), 64'd0);
        chk({tag, ".a_bf_valid"}, 64'(a_bf_valid), 64'd0);
        chk({tag, ".a_bf_masks"}, {a_bf_read_mask, a_bf_write_mask}, 64'd0);
        chk({tag, ".a_bf_wdata"}, 64'(a_bf_write_data), 64'd0);
        chk({tag, ".b_rsp"}, {31'd0, b_rsp_valid, b_rsp_status, b_rsp_read_data}, 64'd0);
        chk({tag, ".b_bf"}, {b_bf_valid, b_bf_read_mask, b_bf_write_mask[30:0]}, 64'd0);
    endtask

    task automatic seed(input logic [DW-1:0] v);
        cor_seed = v;
        cor_base = cor_clears;
    endtask

    // Presents a request and waits for the accepting edge; optionally leaves
    // valid asserted afterwards.
    task automatic do_req(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] data,
                          input logic [DW-1:0] strb, input bit keep);
        int  n0;
        bit  got;
        n0 = acc_q.size();
        got = 1'b0;
        req_address = addr; req_write = wr; req_write_data = data; req_strobe = strb;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (acc_q.size() > n0) begin got = 1'b1; break; end
        end
        if (!keep) req_valid = 1'b0;
        chk("req_accepted", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (a_req_ready) begin got = 1'b1; break; end
        end
        chk("return_to_idle", 64'(got), 64'd1);
    endtask

    int na, nb, p0, pb0, c0, k;

    initial begin
        // Reset: registered outputs all zero, ready once released.
        req_valid = 1'b1;                 // ignored while in reset
        req_address = OFF;
        for (int i = 0; i < 3; i++) tick();
        chk_zero("reset");
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("reset.req_ready", 64'(a_req_ready), 64'd1);
        chk("reset.no_accept", 64'(acc_q.size()), 64'd0);
        chk_zero("after_reset");

        // Read hit.
        seed(32'h1234_5678);
        na = a_obs.size(); nb = b_obs.size(); p0 = a_pulses;
        do_req(OFF, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_idle();
        chk("rd.pulses", 64'(a_pulses - p0), 64'd1);
        chk("rd.read_mask", 64'(last_rmask), 64'hFFFF_FFFF);
        chk("rd.write_mask", 64'(last_wmask), 64'd0);
        chk("rd.rsp", 64'(a_obs[na]), {30'd0, 2'b00, 32'h1234_5678});
        chk("rd.ro_rsp", 64'(b_obs[nb]), {30'd0, 2'b00, 32'h1234_5678});

        // Write hit; the read-only instance reports SLAVE_ERROR.
        na = a_obs.size(); nb = b_obs.size(); p0 = a_pulses; pb0 = b_pulses;
        do_req(OFF, 1'b1, 32'hA5A5_A5A5, 32'h0000_FFFF, 1'b0);
        wait_idle();
        chk("wr.pulses", 64'(a_pulses - p0), 64'd1);
        chk("wr.write_mask", 64'(last_wmask), 64'h0000_FFFF);
        chk("wr.write_data", 64'(last_wdata), 64'hA5A5_A5A5);
        chk("wr.read_mask", 64'(last_rmask), 64'd0);
        chk("wr.rsp", 64'(a_obs[na]), 64'd0);
        chk("wr.ro_pulses", 64'(b_pulses - pb0), 64'd0);
        chk("wr.ro_rsp", 64'(b_obs[nb]), {30'd0, 2'b10, 32'h0});

        // Read miss.
        na = a_obs.size(); p0 = a_pulses;
        do_req(8'h14, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_idle();
        chk("miss.pulses", 64'(a_pulses - p0), 64'd0);
        chk("miss.rsp", 64'(a_obs[na]), {30'd0, 2'b11, 32'h0});

        // Write with zero strobe still strobes the field.
        na = a_obs.size(); p0 = a_pulses;
        do_req(OFF, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0);
        wait_idle();
        chk("wr0.pulses", 64'(a_pulses - p0), 64'd1);
        chk("wr0.write_mask", 64'(last_wmask), 64'd0);
        chk("wr0.rsp", 64'(a_obs[na]), 64'd0);

        // Read with a nonzero strobe: strobe ignored.
        seed(32'hCAFE_F00D);
        na = a_obs.size();
        do_req(OFF, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        chk("rdstrb.write_mask", 64'(last_wmask), 64'd0);
        chk("rdstrb.rsp", 64'(a_obs[na]), {30'd0, 2'b00, 32'hCAFE_F00D});

        // Response back-pressure with a second request waiting.
        seed(32'h5A5A_0001);
        rsp_ready = 1'b0;
        na = a_obs.size(); p0 = a_pulses; c0 = cor_clears;
        do_req(OFF, 1'b0, 32'h0, 32'h0, 1'b1);
        k = acc_q.size();
        for (int i = 0; i < 7; i++) tick();
        chk("stall.rsp_valid", 64'(a_rsp_valid), 64'd1);
        chk("stall.req_ready", 64'(a_req_ready), 64'd0);
        chk("stall.rsp_data", 64'(a_rsp_read_data), 64'h5A5A_0001);
        chk("stall.no_accept", 64'(acc_q.size() - k), 64'd0);
        chk("stall.pulses", 64'(a_pulses - p0), 64'd1);
        rsp_ready = 1'b1;
        tick();
        tick();
        req_valid = 1'b0;
        chk("stall.second_accept", 64'(acc_q.size() - k), 64'd1);
        chk("stall.accept_after_hs", 64'(acc_q[acc_q.size()-1] - hs_q[hs_q.size()-1]), 64'd1);
        wait_idle();
        chk("stall.pulses_total", 64'(a_pulses - p0), 64'd2);
        chk("stall.first_rsp", 64'(a_obs[na]), {30'd0, 2'b00, 32'h5A5A_0001});
        chk("stall.cleared_once", 64'(a_obs[na+1]), 64'd0);
        chk("stall.read_strobes", 64'(cor_clears - c0), 64'd2);

        // Back-to-back writes.
        k = acc_q.size(); p0 = a_pulses;
        do_req(OFF, 1'b1, 32'h1111_1111, 32'hFFFF_FFFF, 1'b0);
        do_req(OFF, 1'b1, 32'h2222_2222, 32'h00FF_00FF, 1'b0);
        do_req(OFF, 1'b1, 32'h3333_3333, 32'hF000_000F, 1'b0);
        wait_idle();
        chk("b2b.gap1", 64'(acc_q[k+1] - acc_q[k]), 64'd3);
        chk("b2b.gap2", 64'(acc_q[k+2] - acc_q[k+1]), 64'd3);
        chk("b2b.pulses", 64'(a_pulses - p0), 64'd3);
        chk("b2b.last_write_data", 64'(last_wdata), 64'h3333_3333);

        // Reset during ACCESS.
        seed(32'h0BAD_F00D);
        do_req(OFF, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        p0 = a_pulses; na = a_obs.size();
        rst_n = 1'b0;
        #1;
        chk_zero("rst_access");
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_access.req_ready", 64'(a_req_ready), 64'd1);
        chk("rst_access.no_pulse", 64'(a_pulses - p0), 64'd0);
        chk("rst_access.no_rsp", 64'(a_obs.size() - na), 64'd0);
        seed(32'h0000_BEEF);
        do_req(OFF, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_idle();
        chk("rst_access.new_read", 64'(a_obs[na]), {30'd0, 2'b00, 32'h0000_BEEF});

        // Reset during RESPONSE.
        rsp_ready = 1'b0;
        seed(32'h7777_0000);
        na = a_obs.size();
        do_req(OFF, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        #2;
        chk("rst_rsp.in_response", 64'(a_rsp_valid), 64'd1);
        p0 = a_pulses;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_rsp");
        for (int i = 0; i < 2; i++) tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        chk("rst_rsp.req_ready", 64'(a_req_ready), 64'd1);
        chk("rst_rsp.dropped", 64'(a_obs.size() - na), 64'd0);
        chk("rst_rsp.no_pulse", 64'(a_pulses - p0), 64'd0);
        seed(32'h0000_0042);
        do_req(OFF, 1'b0, 32'h0, 32'h0, 1'b0);
        wait_idle();
        chk("rst_rsp.new_read", 64'(a_obs[na]), {30'd0, 2'b00, 32'h0000_0042});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
